// File: rtl/jtriders_cabio_pkg.sv
// Shared types and constants for the riders-family cabinet I/O block.
package jtriders_cabio_pkg;

    // ADC0834 serial protocol phases
    typedef enum logic [2:0] {
        ADC_IDLE,
        ADC_START,
        ADC_MUX,
        ADC_SETTLE,
        ADC_MSB,
        ADC_LSB,
        ADC_DONE
    } adc_st_e;

    // Read word addresses (addr[3:1])
    localparam logic [2:0] RD_JOY12 = 3'd0;
    localparam logic [2:0] RD_JOY34 = 3'd1;
    localparam logic [2:0] RD_SYS   = 3'd2;
    localparam logic [2:0] RD_DSW   = 3'd3;
    localparam logic [2:0] RD_CAB34 = 3'd4;

    // Write word addresses
    localparam logic [2:0] WR_ADC   = 3'd0;
    localparam logic [2:0] WR_COIN  = 3'd1;

    // Serial frame lengths
    localparam int ADC_MUX_BITS = 3;
    localparam int ADC_MSB_BITS = 8;
    localparam int ADC_LSB_BITS = 7;

    // Widest board the read map can describe
    localparam int MAXP = 4;
    localparam int MAXDIP = 20;

endpackage

// File: rtl/jtriders_adc0834.sv
// Emulated ADC0834: serial mux address in on sclk rises, result out
// MSB-first then LSB-first on sclk falls. Absent channels arrive as zero.
module jtriders_adc0834
    import jtriders_cabio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n_i,
    input  logic                 sclk_i,
    input  logic                 di_i,
    input  logic [MAXP-1:0][7:0] analog_i,
    output logic                 do_o
);

    localparam logic [2:0] MUX_LAST = 3'(ADC_MUX_BITS - 1);
    localparam logic [2:0] MSB_LAST = 3'(ADC_MSB_BITS - 1);
    localparam logic [2:0] LSB_LAST = 3'(ADC_LSB_BITS - 1);

    adc_st_e    st_q, st_d;
    logic       sclk_prev_q, cs_prev_q;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] mux_q, mux_d;
    logic [7:0] sr_q, sr_d;
    logic       do_q, do_d;

    logic       rise, fall, cs_fall;
    logic [1:0] chan;

    assign rise    =  sclk_i & ~sclk_prev_q;
    assign fall    = ~sclk_i &  sclk_prev_q;
    assign cs_fall =  cs_prev_q & ~cs_n_i;
    // mux bits arrive sgl, odd, sel1; channel is {sel1, odd}
    assign chan    = {mux_q[0], mux_q[1]};

    // State and shift registers; previous sclk/cs_n kept for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= ADC_IDLE;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            cnt_q       <= '0;
            mux_q       <= '0;
            sr_q        <= '0;
            do_q        <= 1'b1;
        end else begin
            st_q        <= st_d;
            sclk_prev_q <= sclk_i;
            cs_prev_q   <= cs_n_i;
            cnt_q       <= cnt_d;
            mux_q       <= mux_d;
            sr_q        <= sr_d;
            do_q        <= do_d;
        end
    end

    // Next-state: cs_n high overrides everything, including a coincident sclk edge
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        mux_d = mux_q;
        sr_d  = sr_q;
        do_d  = do_q;
        if (cs_n_i) begin
            st_d  = ADC_IDLE;
            cnt_d = '0;
            do_d  = 1'b1;
        end else begin
            case (st_q)
                ADC_IDLE: begin
                    if (cs_fall) st_d = ADC_START;
                end
                ADC_START: begin
                    if (rise && di_i) begin
                        st_d  = ADC_MUX;
                        cnt_d = '0;
                    end
                end
                ADC_MUX: begin
                    if (rise) begin
                        mux_d = {mux_q[1:0], di_i};
                        if (cnt_q == MUX_LAST) begin
                            st_d  = ADC_SETTLE;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ADC_SETTLE: begin
                    if (rise) begin
                        sr_d  = analog_i[chan];
                        st_d  = ADC_MSB;
                        cnt_d = '0;
                    end
                end
                ADC_MSB: begin
                    // rotate left: after 8 falls sr is back to the sample
                    if (fall) begin
                        do_d = sr_q[7];
                        sr_d = {sr_q[6:0], sr_q[7]};
                        if (cnt_q == MSB_LAST) begin
                            st_d  = ADC_LSB;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ADC_LSB: begin
                    // rotate right: bit1 first, bit7 last (bit0 is not repeated)
                    if (fall) begin
                        do_d = sr_q[1];
                        sr_d = {sr_q[0], sr_q[7:1]};
                        if (cnt_q == LSB_LAST) begin
                            st_d  = ADC_DONE;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ADC_DONE: begin
                    if (fall) do_d = 1'b1;
                end
                default: st_d = ADC_IDLE;
            endcase
        end
    end

    assign do_o = do_q;

endmodule

// File: rtl/jtriders_cabio.sv
// Cabinet I/O for riders-family boards: read mux, coin pulse stretch,
// coin counter and ADC control writes.
module jtriders_cabio
    import jtriders_cabio_pkg::*;
#(
    parameter int PLAYERS   = 4,
    parameter int DIPW      = 20,
    parameter int COIN_HOLD = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_cen,
    input  logic                 cs,
    input  logic                 we,
    input  logic [3:1]           addr,
    input  logic [7:0]           din,
    input  logic [DIPW-1:0]      dipsw,
    input  logic [PLAYERS*7-1:0] joystick,
    input  logic [PLAYERS*8-1:0] analog,
    input  logic [PLAYERS-1:0]   cab_1p,
    input  logic [PLAYERS-1:0]   coin,
    input  logic                 service,
    input  logic                 dip_test,
    input  logic                 dma,
    output logic [15:0]          dout,
    output logic [PLAYERS-1:0]   coin_cnt
);

    localparam int CW = $clog2(COIN_HOLD + 1);

    logic                 wr;
    logic                 adc_cs_n_q, adc_sclk_q, adc_di_q;
    logic [PLAYERS-1:0]   coin_cnt_q;
    logic [15:0]          dout_q, dout_d;
    logic                 adc_do;

    logic [PLAYERS-1:0]   c1_q, c2_q, c3_q;
    logic [CW-1:0]        hold_q [PLAYERS];
    logic [CW-1:0]        hold_d [PLAYERS];

    logic [MAXP-1:0][6:0] joy_pad;
    logic [MAXP-1:0][7:0] ana_pad;
    logic [MAXP-1:0]      cab_pad;
    logic [MAXP-1:0]      coin_st;
    logic [MAXDIP-1:0]    dsw_pad;

    logic                 unused_din;
    assign unused_din = ^din[7:3];

    assign wr = cs & we & cpu_cen;

    // Normalise to the four-player / 20-bit DIP map; missing fields read as 1
    // (analog reads as 0 so an absent ADC channel converts to 8'h00)
    for (genvar p = 0; p < MAXP; p++) begin : g_slot
        if (p < PLAYERS) begin : g_on
            assign joy_pad[p] = joystick[p*7 +: 7];
            assign ana_pad[p] = analog[p*8 +: 8];
            assign cab_pad[p] = cab_1p[p];
            assign coin_st[p] = c2_q[p] & (hold_q[p] == '0);
        end else begin : g_off
            assign joy_pad[p] = 7'h7f;
            assign ana_pad[p] = 8'h00;
            assign cab_pad[p] = 1'b1;
            assign coin_st[p] = 1'b1;
        end
    end

    for (genvar i = 0; i < MAXDIP; i++) begin : g_dsw
        if (i < DIPW) begin : g_on
            assign dsw_pad[i] = dipsw[i];
        end else begin : g_off
            assign dsw_pad[i] = 1'b1;
        end
    end

    // CPU write registers: ADC serial lines and coin counter drive
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_cs_n_q <= 1'b1;
            adc_sclk_q <= 1'b0;
            adc_di_q   <= 1'b0;
            coin_cnt_q <= '0;
        end else if (wr) begin
            if (addr == WR_ADC) begin
                adc_cs_n_q <= din[0];
                adc_sclk_q <= din[1];
                adc_di_q   <= din[2];
            end
            if (addr == WR_COIN) coin_cnt_q <= din[PLAYERS-1:0];
        end
    end

    // Coin synchronisers and hold counters
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_q <= '1;
            c2_q <= '1;
            c3_q <= '1;
            for (int i = 0; i < PLAYERS; i++) hold_q[i] <= '0;
        end else begin
            c1_q <= coin;
            c2_q <= c1_q;
            c3_q <= c2_q;
            for (int i = 0; i < PLAYERS; i++) hold_q[i] <= hold_d[i];
        end
    end

    // Falling edge of the synced coin (re)loads the hold; cpu_cen counts it down
    always_comb begin
        for (int i = 0; i < PLAYERS; i++) begin
            hold_d[i] = hold_q[i];
            if (c3_q[i] && !c2_q[i])
                hold_d[i] = CW'(COIN_HOLD);
            else if (cpu_cen && hold_q[i] != '0)
                hold_d[i] = hold_q[i] - 1'b1;
        end
    end

    // Read word select
    always_comb begin
        dout_d = 16'hffff;
        case (addr)
            RD_JOY12: dout_d = {1'b1, joy_pad[1], adc_do, joy_pad[0]};
            RD_JOY34: dout_d = {1'b1, joy_pad[3], 1'b1, joy_pad[2]};
            RD_SYS:   dout_d = {dsw_pad[19:16], dma, dip_test, cab_pad[1:0],
                                3'b111, service, coin_st};
            RD_DSW:   dout_d = dsw_pad[15:0];
            RD_CAB34: dout_d = {8'hff, 6'h3f, cab_pad[3:2]};
            default:  dout_d = 16'hffff;
        endcase
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (rst) dout_q <= 16'hffff;
        else     dout_q <= dout_d;
    end

    jtriders_adc0834 u_adc (
        .clk      (clk),
        .rst      (rst),
        .cs_n_i   (adc_cs_n_q),
        .sclk_i   (adc_sclk_q),
        .di_i     (adc_di_q),
        .analog_i (ana_pad),
        .do_o     (adc_do)
    );

    assign dout     = dout_q;
    assign coin_cnt = coin_cnt_q;

endmodule

// File: doc/jtriders_cabio.md
# jtriders_cabio

Parametrised cabinet I/O block for the Konami riders-family boards, successor to the fixed four-word input mux. It returns joysticks, coins, service/test, DMA status and DIP switches on a 16-bit CPU read bus for 2–4 players. It adds coin-pulse stretching so short coin pulses are not missed by CPU polling, CPU-driven coin-counter outputs, and an emulated ADC0834 serial converter for analogue controls. It sits between the cabinet/MiSTer input wrapper and the main 68000 bus decoder.

## Interface
Parameters:
- PLAYERS, 4, number of player slots (2–4); absent slots read as all 1s.
- DIPW, 20, DIP switch width (16–20).
- COIN_HOLD, 4096, cpu_cen ticks a coin bit stays asserted after a falling edge.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_cen  in  1  CPU clock enable
- cs  in  1  chip select from bus decoder
- we  in  1  write strobe, qualified by cs and cpu_cen
- addr  in  [3:1]  word select
- din  in  8  CPU write data, low byte
- dipsw  in  DIPW  DIP switches
- joystick  in  PLAYERS*7  player p at [p*7+6:p*7], active low
- analog  in  PLAYERS*8  8-bit ADC value per channel
- cab_1p  in  PLAYERS  start buttons, active low
- coin  in  PLAYERS  raw coin inputs, active low
- service, dip_test, dma  in  1 each  status bits
- dout  out  16  registered read data
- coin_cnt  out  PLAYERS  coin counter drive, active high

## Operation
- Read map (dout reloaded every clk from addr; absent fields = 1):
  - 0: {1, joy2, adc_do, joy1}
  - 1: {1, joy4, 1, joy3}
  - 2: {dsw_hi[3:0], dma, dip_test, cab_1p[1:0], 3'b111, service, coin_st[3:0]}; dsw_hi = dipsw[DIPW-1:16] padded with 1s
  - 3: dipsw[15:0]
  - 4: {8'hff, 6'h3f, cab_1p[3:2]}
  - 5–7: 16'hffff
- Writes (cs & we & cpu_cen):
  - addr 0: din[0] adc_cs_n, din[1] adc_sclk, din[2] adc_di
  - addr 1: coin_cnt <= din[PLAYERS-1:0]
  - other addresses ignored
- Coin stretch, per coin:
  - coin synchronised through 2 flops
  - synced falling edge loads counter with COIN_HOLD
  - counter decrements on cpu_cen down to 0
  - coin_st = 0 while counter != 0 or synced input low
  - new edge while counting reloads the counter
- ADC0834 emulation, states IDLE, START, MUX, SETTLE, MSB, LSB, DONE:
  - adc_cs_n high: go to IDLE with adc_do = 1 on the next clk, from any state.
  - Events are edges of the written adc_sclk register (rise/fall detected against its previous value).
  - IDLE→START when adc_cs_n falls.
  - START: on rise with di=1, go to MUX.
  - MUX: shift 3 bits on rises (sgl, odd, sel1); channel = {sel1, odd}; then SETTLE.
  - SETTLE: on rise, latch analog[channel] into an 8-bit shift register; channel >= PLAYERS latches 8'h00.
  - MSB: 8 falls drive bit7..bit0 on adc_do.
  - LSB: 7 falls drive bit1..bit7.
  - DONE: adc_do = 1 until adc_cs_n rises.

## Timing
- Reset values: dout 16'hffff; coin_cnt 0; adc_do 1; ADC state IDLE; adc_cs_n 1; adc_sclk 0; adc_di 0; coin counters 0.
- dout latency: 1 clk from an addr change.
- coin_st latency: 3 clk from a raw coin edge to dout content, plus 1 clk register.
- Write effects are visible on the clk after the qualified write.
- ADC state and adc_do update on the clk after the sclk/cs_n register changes.
- If a write toggles adc_cs_n and adc_sclk together, cs_n wins: IDLE, and the clock edge is ignored.
- rst mid-conversion aborts to IDLE; rst mid-stretch clears counters.

## Structure
- Package jtriders_cabio_pkg:
  - ADC state enum
  - read/write word address constants
  - ADC bit count constants (3 mux bits, 8 MSB, 7 LSB)
- Sub-module jtriders_adc0834 holds the serial state machine and shift register; the top holds the read mux, coin stretch and write decode.

## Test plan
- After rst, read addr 0–7 with all inputs idle (1s) and dipsw=20'h5a5a5 → word2 = 16'h5fff (dma=1, dip_test=1), word3 = 16'ha5a5, all others 16'hffff except adc_do=1.
- Coin0 low for 2 clk, COIN_HOLD=16 → word2 bit0 = 0 for 16 cpu_cen ticks then returns to 1; second pulse mid-hold restarts the 16 ticks.
- Write addr 1 din=8'h05, PLAYERS=4 → coin_cnt = 4'b0101 next clk.
- ADC: cs_n low, clock in start=1, sgl=1, odd=1, sel1=0 with analog ch1=8'hA5 → adc_do sequence 1,0,1,0,0,1,0,1 then 0,1,0,0,1,0,1, then 1.
- Raise cs_n after 3 MSB bits → adc_do=1 and IDLE next clk; a new conversion of ch3 with PLAYERS=2 returns 8'h00.
- Assert rst during LSB phase and during coin hold → adc_do=1, coin_st=1 on the next clk.
